// File: rtl/demux_sched.sv
// demux_sched: credit-based round-robin demultiplexer from one upstream stream onto
// four downstream channels. A channel is eligible when enabled and holding credit.
// The grant search starts just after the last-granted channel. Outputs are
// registered, giving one cycle of latency from acceptance to the strobe.
// Optional feature: define DEMUX_SCHED_CNT_EN to add a 16-bit wrapping transfer
// counter on output xfer_cnt.
module demux_sched #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        ch_en,
  input  logic [3:0]        credit_ret,
  output logic [3:0]        out_valid,
  output logic [1:0]        out_sel,
  output logic [DATA_W-1:0] out_data
`ifdef DEMUX_SCHED_CNT_EN
  ,
  output logic [15:0]       xfer_cnt
`endif
);

  localparam logic [3:0] CredMax = 4'(CREDITS);

  logic [3:0]        credit_q [4];
  logic [3:0]        credit_d [4];
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        out_valid_q, out_valid_d;
  logic [1:0]        out_sel_q, out_sel_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [3:0] eligible;
  logic [1:0] grant;
  logic [1:0] idx;
  logic       found;
  logic       xfer;
  logic [3:0] send;

  // Eligibility: enabled and at least one credit left.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = ch_en[i] && (credit_q[i] != 4'd0);
    end
  end

  // Depends only on state and ch_en, never on in_valid.
  assign in_ready = |eligible;
  assign xfer     = in_valid && in_ready;

  // Round-robin search: ptr+1, ptr+2, ptr+3, then ptr itself.
  always_comb begin
    grant = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && eligible[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign send = xfer ? (4'b0001 << grant) : 4'b0000;

  // Next-state for pointer, registered outputs and credit counters.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = send;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    if (xfer) begin
      ptr_d      = grant;
      out_sel_d  = grant;
      out_data_d = in_data;
    end
    for (int i = 0; i < 4; i++) begin
      credit_d[i] = credit_q[i];
      // A send and a return in the same cycle cancel out.
      if (send[i] && !credit_ret[i]) begin
        credit_d[i] = credit_q[i] - 4'd1;
      end else if (!send[i] && credit_ret[i] && (credit_q[i] != CredMax)) begin
        credit_d[i] = credit_q[i] + 4'd1;
      end
    end
  end

  // State registers; reset points ptr at 3 so channel 0 is granted first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 2'd3;
      out_valid_q <= '0;
      out_sel_q   <= '0;
      out_data_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        credit_q[i] <= CredMax;
      end
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < 4; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign out_data  = out_data_q;

`ifdef DEMUX_SCHED_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Transfer counter, wraps naturally at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_sched.sv
// Directed testbench for demux_sched (CREDITS=4, DATA_W=8). Covers reset state,
// round-robin order, credit exhaustion and return, channel skipping, simultaneous
// send/return, reset mid-operation and, with DEMUX_SCHED_CNT_EN, counter wrap.
module tb_demux_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [3:0] ch_en = 4'h0;
  logic [3:0] credit_ret = 4'h0;
  logic [3:0] out_valid;
  logic [1:0] out_sel;
  logic [7:0] out_data;
`ifdef DEMUX_SCHED_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  demux_sched #(
    .DATA_W (8),
    .CREDITS(4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ch_en     (ch_en),
    .credit_ret(credit_ret),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_data  (out_data)
`ifdef DEMUX_SCHED_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    credit_ret = 4'h0;
    rst        = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  logic [3:0] exp_v;
  logic [1:0] exp_s;

  initial begin
    // Reset state
    ch_en = 4'hF;
    do_reset();
    check_eq("rst_valid", out_valid, 4'h0);
    check_eq("rst_sel", out_sel, 2'd0);
    check_eq("rst_data", out_data, 8'h00);
    check_eq("rst_ready", in_ready, 1'b1);

    // Round-robin over all four channels
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h10 + 8'(i);
      check_eq("rr_ready", in_ready, 1'b1);
      cyc();
      exp_s = 2'(i % 4);
      exp_v = 4'b0001 << exp_s;
      check_eq("rr_valid", out_valid, exp_v);
      check_eq("rr_sel", out_sel, exp_s);
      check_eq("rr_data", out_data, 8'h10 + 8'(i));
    end
    in_valid = 1'b0;
    cyc();
    check_eq("rr_idle_valid", out_valid, 4'h0);
    check_eq("rr_hold_sel", out_sel, 2'd3);
    check_eq("rr_hold_data", out_data, 8'h17);

    // Credit exhaustion on channel 0
    do_reset();
    ch_en    = 4'b0001;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'h20 + 8'(i);
      check_eq("ex_ready", in_ready, (i < 4) ? 1'b1 : 1'b0);
      cyc();
      check_eq("ex_valid", out_valid, (i < 4) ? 4'b0001 : 4'b0000);
    end
    check_eq("ex_hold_data", out_data, 8'h23);
    check_eq("ex_hold_sel", out_sel, 2'd0);
    in_valid   = 1'b0;
    credit_ret = 4'b0001;
    cyc();
    credit_ret = 4'b0000;
    check_eq("ex_ret_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h2A;
    cyc();
    check_eq("ex_one_valid", out_valid, 4'b0001);
    check_eq("ex_one_data", out_data, 8'h2A);
    check_eq("ex_empty_ready", in_ready, 1'b0);
    cyc();
    check_eq("ex_none_valid", out_valid, 4'b0000);
    in_valid = 1'b0;

    // Skipping disabled channels
    do_reset();
    ch_en    = 4'b1010;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'h30 + 8'(i);
      cyc();
      exp_s = (i % 2 == 0) ? 2'd1 : 2'd3;
      exp_v = 4'b0001 << exp_s;
      check_eq("sk_sel", out_sel, exp_s);
      check_eq("sk_valid", out_valid, exp_v);
    end
    in_valid = 1'b0;

    // Simultaneous send and return on channel 2 at credit 1
    do_reset();
    ch_en    = 4'b0100;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h40 + 8'(i);
      cyc();
    end
    credit_ret = 4'b0100;
    in_data    = 8'h43;
    cyc();
    credit_ret = 4'b0000;
    check_eq("sim_valid", out_valid, 4'b0100);
    check_eq("sim_ready_c1", in_ready, 1'b1);
    in_data = 8'h44;
    cyc();
    check_eq("sim_last_valid", out_valid, 4'b0100);
    check_eq("sim_ready_c0", in_ready, 1'b0);
    in_valid = 1'b0;

    // Return at full credit is ignored
    do_reset();
    ch_en      = 4'b0100;
    credit_ret = 4'b0100;
    cyc();
    credit_ret = 4'b0000;
    in_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("sat_ready", in_ready, 1'b1);
      cyc();
    end
    check_eq("sat_empty", in_ready, 1'b0);
    in_valid = 1'b0;

    // Reset mid-operation
    do_reset();
    ch_en    = 4'hF;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hA0 + 8'(i);
      cyc();
    end
    check_eq("mid_pre_valid", out_valid, 4'b0100);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 4'h0);
    check_eq("mid_rst_data", out_data, 8'h00);
    cyc();
    rst = 1'b0;
    cyc();
    check_eq("mid_no_strobe", out_valid, 4'h0);
    in_valid = 1'b1;
    in_data  = 8'hB0;
    cyc();
    check_eq("mid_first_sel", out_sel, 2'd0);
    check_eq("mid_first_valid", out_valid, 4'b0001);
    ch_en = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      check_eq("mid_cred_ready", in_ready, 1'b1);
      cyc();
    end
    check_eq("mid_cred_empty", in_ready, 1'b0);
    in_valid = 1'b0;

`ifdef DEMUX_SCHED_CNT_EN
    // Transfer counter wrap
    do_reset();
    check_eq("cnt_rst", xfer_cnt, 16'h0000);
    ch_en      = 4'hF;
    credit_ret = 4'hF;
    in_valid   = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
    end
    #1;
    check_eq("cnt_max", xfer_cnt, 16'hFFFF);
    cyc();
    check_eq("cnt_wrap", xfer_cnt, 16'h0000);
    in_valid   = 1'b0;
    credit_ret = 4'h0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
